// File: rtl/mem_bus_arbiter.sv
// Arbiter for the shared SDR memory bus between ICache and DCache.
// Grants one owner per burst, counts beats, and aborts a stalled burst via a watchdog.
module mem_bus_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 3,
  parameter int TIMEOUT   = 255,
  parameter int TMO_W     = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             IReq,
  input  logic             IRW,
  input  logic             DReq,
  input  logic             DRW,
  input  logic             mSDR_RxD,
  input  logic             mSDR_TxD,
  output logic             IGrant,
  output logic             DGrant,
  output logic             MStrobe,
  output logic             MRW,
  output logic             Busy,
  output logic             Timeout,
  output logic [CNT_W-1:0] BeatCnt
);

  // state | meaning
  // IDLE  | bus free, arbitrate between pending requests
  // XFER  | burst in progress for the latched owner
  // DONE  | one-cycle bus gap after a burst, fairness bit updated
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT);

  state_t             state_q, state_d;
  logic               owner_d_q, owner_d_d;
  logic               rw_q, rw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   wdog_q, wdog_d;
  logic               tmo_q, tmo_d;
  logic               last_d_q, last_d_d;
  logic               sel_d;
  logic               beat;

  assign beat = mSDR_RxD | mSDR_TxD;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      owner_d_q <= 1'b0;
      rw_q      <= 1'b0;
      cnt_q     <= '0;
      wdog_q    <= '0;
      tmo_q     <= 1'b0;
      last_d_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_d_q <= owner_d_d;
      rw_q      <= rw_d;
      cnt_q     <= cnt_d;
      wdog_q    <= wdog_d;
      tmo_q     <= tmo_d;
      last_d_q  <= last_d_d;
    end
  end

  // Watchdog is a down-counter: reload on grant or beat, abort when it has hit zero.
  always_comb begin
    state_d   = state_q;
    owner_d_d = owner_d_q;
    rw_d      = rw_q;
    cnt_d     = cnt_q;
    wdog_d    = wdog_q;
    tmo_d     = 1'b0;
    last_d_d  = last_d_q;
    sel_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (IReq || DReq) begin
          // DCache wins a tie unless it owned the previous burst
          sel_d     = DReq & (~IReq | ~last_d_q);
          owner_d_d = sel_d;
          rw_d      = sel_d ? DRW : IRW;
          wdog_d    = TMO_LOAD;
          state_d   = XFER;
        end
      end
      XFER: begin
        if (beat) begin
          cnt_d  = cnt_q + CNT_W'(1);
          wdog_d = TMO_LOAD;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end else if (wdog_q == '0) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end else begin
          wdog_d = wdog_q - TMO_W'(1);
        end
      end
      DONE: begin
        last_d_d = owner_d_q;
        cnt_d    = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign IGrant  = (state_q == XFER) & ~owner_d_q;
  assign DGrant  = (state_q == XFER) &  owner_d_q;
  assign MStrobe = (state_q == XFER);
  assign MRW     = (state_q == XFER) & rw_q;
  assign Busy    = (state_q != IDLE);
  assign Timeout = tmo_q;
  assign BeatCnt = cnt_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of bus ownership.
module tb_mem_bus_arbiter;
  localparam int BURST_LEN = 4;
  localparam int CNT_W     = 3;
  localparam int TIMEOUT   = 255;
  localparam int TMO_W     = 8;

  logic Clk = 1'b0, Reset = 1'b1;
  logic IReq = 1'b0, IRW = 1'b0, DReq = 1'b0, DRW = 1'b0;
  logic mSDR_RxD = 1'b0, mSDR_TxD = 1'b0;
  logic IGrant, DGrant, MStrobe, MRW, Busy, Timeout;
  logic [CNT_W-1:0] BeatCnt;

  int checks = 0;
  int passed = 0;

  // model: owner 0=none 1=ICache 2=DCache
  int m_owner, m_last_owner, m_beats, m_quiet;
  bit m_gap, m_rw, m_last_d, m_tmo;

  mem_bus_arbiter #(.BURST_LEN(BURST_LEN), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) dut (
    .Clk(Clk), .Reset(Reset), .IReq(IReq), .IRW(IRW), .DReq(DReq), .DRW(DRW),
    .mSDR_RxD(mSDR_RxD), .mSDR_TxD(mSDR_TxD), .IGrant(IGrant), .DGrant(DGrant),
    .MStrobe(MStrobe), .MRW(MRW), .Busy(Busy), .Timeout(Timeout), .BeatCnt(BeatCnt)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [8:0] dut_vec();
    return {IGrant, DGrant, MStrobe, MRW, Busy, Timeout, BeatCnt};
  endfunction

  function automatic logic [8:0] mdl_vec();
    logic own;
    own = (m_owner != 0);
    return {logic'(m_owner == 1), logic'(m_owner == 2), own, own & m_rw,
            own | m_gap, m_tmo, 3'(m_beats)};
  endfunction

  task automatic model_reset();
    m_owner = 0; m_last_owner = 0; m_beats = 0; m_quiet = 0;
    m_gap = 0; m_rw = 0; m_last_d = 0; m_tmo = 0;
  endtask

  task automatic model_step();
    bit fin;
    if (Reset) begin
      model_reset();
      return;
    end
    m_tmo = 0;
    fin = 0;
    if (m_owner != 0) begin
      if (mSDR_RxD || mSDR_TxD) begin
        m_beats++;
        m_quiet = 0;
        if (m_beats == BURST_LEN) fin = 1;
      end else if (m_quiet == TIMEOUT) begin
        m_tmo = 1;
        fin = 1;
      end else begin
        m_quiet++;
      end
      if (fin) begin
        m_last_owner = m_owner;
        m_owner = 0;
        m_gap = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
      m_last_d = (m_last_owner == 2);
      m_beats = 0;
    end else if (IReq || DReq) begin
      if (IReq && DReq) m_owner = m_last_d ? 1 : 2;
      else m_owner = DReq ? 2 : 1;
      m_rw = (m_owner == 2) ? DRW : IRW;
      m_beats = 0;
      m_quiet = 0;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic drain();
    int n;
    IReq = 0; DReq = 0; mSDR_RxD = 1; mSDR_TxD = 0;
    n = 0;
    while ((Busy !== 1'b0 || m_owner != 0 || m_gap) && n < 20) begin
      tick();
      n++;
    end
    mSDR_RxD = 0;
    if (n >= 20) begin
      checks++;
      $display("FAIL drain_to_idle: Busy=%b still set after %0d cycles", Busy, n);
    end
  endtask

  task automatic test_reset();
    Reset = 1;
    repeat (3) tick();
    checks++;
    if (dut_vec() !== 9'b0) $display("FAIL reset_outputs: got %b want %b", dut_vec(), 9'b0);
    else passed++;
    Reset = 0;
    tick();
    checks++;
    if (dut_vec() !== mdl_vec()) $display("FAIL reset_idle: got %b want %b", dut_vec(), mdl_vec());
    else passed++;
  endtask

  task automatic test_read_burst();
    DReq = 1; DRW = 1;
    tick();
    checks++;
    if ({DGrant, IGrant, MStrobe, MRW} !== 4'b1011)
      $display("FAIL read_grant: got %b want %b", {DGrant, IGrant, MStrobe, MRW}, 4'b1011);
    else passed++;
    for (int b = 0; b < BURST_LEN; b++) begin
      mSDR_RxD = 1;
      tick();
      mSDR_RxD = 0;
      checks++;
      if (dut_vec() !== mdl_vec()) $display("FAIL read_beat%0d: got %b want %b", b, dut_vec(), mdl_vec());
      else passed++;
      if (b < BURST_LEN - 1) begin
        tick();
        checks++;
        if (dut_vec() !== mdl_vec()) $display("FAIL read_gap%0d: got %b want %b", b, dut_vec(), mdl_vec());
        else passed++;
      end
    end
    checks++;
    if ({DGrant, Busy, BeatCnt} !== {1'b0, 1'b1, 3'd4})
      $display("FAIL read_done: got %b want %b", {DGrant, Busy, BeatCnt}, {1'b0, 1'b1, 3'd4});
    else passed++;
    DReq = 0;
    tick();
    checks++;
    if (dut_vec() !== 9'b0) $display("FAIL read_idle: got %b want %b", dut_vec(), 9'b0);
    else passed++;
  endtask

  task automatic test_alternation();
    int q[$];
    logic prev;
    int order;
    Reset = 1;
    tick();
    Reset = 0;
    IReq = 1; IRW = 1; DReq = 1; DRW = 1; mSDR_RxD = 1;
    prev = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) $display("FAIL alt_cycle%0d: got %b want %b", c, dut_vec(), mdl_vec());
      else passed++;
      if ((IGrant | DGrant) && !prev) q.push_back(DGrant ? 2 : 1);
      prev = IGrant | DGrant;
    end
    order = (q.size() >= 3) ? q[0] * 100 + q[1] * 10 + q[2] : 0;
    checks++;
    if (order !== 212) $display("FAIL alt_order: got %0d want %0d (2=D 1=I)", order, 212);
    else passed++;
    drain();
  endtask

  task automatic test_flush_gaps();
    DReq = 1; DRW = 0;
    tick();
    for (int b = 0; b < BURST_LEN; b++) begin
      repeat (2) begin
        tick();
        checks++;
        if ({DGrant, MRW} !== 2'b10) $display("FAIL flush_hold%0d: got %b want %b", b, {DGrant, MRW}, 2'b10);
        else passed++;
      end
      mSDR_TxD = 1;
      tick();
      mSDR_TxD = 0;
      checks++;
      if (dut_vec() !== mdl_vec()) $display("FAIL flush_beat%0d: got %b want %b", b, dut_vec(), mdl_vec());
      else passed++;
    end
    checks++;
    if ({DGrant, MStrobe, MRW, BeatCnt} !== {3'b000, 3'd4})
      $display("FAIL flush_release: got %b want %b", {DGrant, MStrobe, MRW, BeatCnt}, {3'b000, 3'd4});
    else passed++;
    DReq = 0;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    bit found;
    IReq = 1; IRW = 1;
    tick();
    checks++;
    if (IGrant !== 1'b1) $display("FAIL tmo_grant: got %b want %b", IGrant, 1'b1);
    else passed++;
    n = 0;
    found = 0;
    while (!found && n < TIMEOUT + 20) begin
      tick();
      n++;
      checks++;
      if (dut_vec() !== mdl_vec()) $display("FAIL tmo_cycle%0d: got %b want %b", n, dut_vec(), mdl_vec());
      else passed++;
      if (Timeout === 1'b1) found = 1;
    end
    checks++;
    if (!found || n != TIMEOUT + 1) $display("FAIL tmo_latency: got %0d want %0d", found ? n : -1, TIMEOUT + 1);
    else passed++;
    checks++;
    if (IGrant !== 1'b0) $display("FAIL tmo_release: got %b want %b", IGrant, 1'b0);
    else passed++;
    IReq = 0;
    tick();
    checks++;
    if ({Busy, Timeout} !== 2'b00) $display("FAIL tmo_idle: got %b want %b", {Busy, Timeout}, 2'b00);
    else passed++;
  endtask

  task automatic test_reset_mid_burst();
    DReq = 1; DRW = 1;
    tick();
    mSDR_RxD = 1;
    repeat (2) tick();
    mSDR_RxD = 0;
    checks++;
    if (BeatCnt !== 3'd2) $display("FAIL rst_pre_beats: got %0d want %0d", BeatCnt, 2);
    else passed++;
    Reset = 1;
    #1;
    checks++;
    if (dut_vec() !== 9'b0) $display("FAIL rst_async: got %b want %b", dut_vec(), 9'b0);
    else passed++;
    tick();
    Reset = 0;
    tick();
    checks++;
    if ({DGrant, MStrobe, BeatCnt} !== {2'b11, 3'd0})
      $display("FAIL rst_regrant: got %b want %b", {DGrant, MStrobe, BeatCnt}, {2'b11, 3'd0});
    else passed++;
    checks++;
    if (dut_vec() !== mdl_vec()) $display("FAIL rst_regrant_model: got %b want %b", dut_vec(), mdl_vec());
    else passed++;
    drain();
  endtask

  task automatic test_withdraw();
    int fall, rise;
    logic pi, pd;
    IReq = 1; IRW = 1;
    tick();
    mSDR_RxD = 1;
    tick();
    IReq = 0; DReq = 1; DRW = 1'($urandom_range(0, 1));
    fall = -1; rise = -1;
    pi = IGrant; pd = DGrant;
    for (int c = 0; c < 14; c++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) $display("FAIL wd_cycle%0d: got %b want %b", c, dut_vec(), mdl_vec());
      else passed++;
      if (pi && !IGrant && fall < 0) fall = c;
      if (!pd && DGrant && rise < 0) rise = c;
      pi = IGrant; pd = DGrant;
    end
    checks++;
    if (fall < 0 || rise - fall != 2) $display("FAIL wd_handover: got gap %0d want %0d", rise - fall, 2);
    else passed++;
    drain();
  endtask

  task automatic test_random();
    int rate;
    int errs;
    rate = 2;
    errs = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 0) rate = $urandom_range(0, 4);
      Reset    = ($urandom_range(0, 499) == 0);
      IReq     = ($urandom_range(0, 2) != 0);
      DReq     = ($urandom_range(0, 2) != 0);
      IRW      = 1'($urandom_range(0, 1));
      DRW      = 1'($urandom_range(0, 1));
      mSDR_RxD = ($urandom_range(0, 3) < rate);
      mSDR_TxD = ($urandom_range(0, 7) < rate);
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        if (errs < 10) $display("FAIL rand_cycle%0d: got %b want %b", c, dut_vec(), mdl_vec());
        errs++;
      end else passed++;
    end
    Reset = 0;
    drain();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_read_burst();
    test_alternation();
    test_flush_gaps();
    test_timeout();
    test_reset_mid_burst();
    test_withdraw();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
